nexus_nonce_collector: RTL

- Sits directly downstream of the hash transform cores.
- Captures the per-core `GoodNonceFound` pulses and their `NonceOut` values, merges them round-robin into a FIFO, and serializes each nonce as a framed byte stream toward the host UART/TX path.
- Final target filtering is done by the miner software; this block must never lose a nonce silently. Every loss is counted and flagged.

---
 rtl/nexus_nonce_collector_pkg.sv | 13 +
 rtl/nexus_nonce_collector_if.sv | 9 +
 rtl/nexus_nonce_fifo.sv | 52 +++++
 rtl/nexus_nonce_collector.sv | 125 ++++++++++++
 4 files changed

// File: rtl/nexus_nonce_collector_pkg.sv
// nexus_pkg: shared constants, serializer state type and drop-counter helper for the nonce collector.
package nexus_pkg;
  localparam int NONCE_W = 64;
  localparam logic [7:0] FRAME_HDR = 8'h4E;
  localparam int FRAME_BYTES = 8;
  localparam int DROP_W = 16;
  typedef enum logic [1:0] {IDLE, HDR, DATA} ser_state_e;
  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a, input logic [DROP_W-1:0] n);
    logic [DROP_W:0] s;
    s = {1'b0, a} + {1'b0, n};
    return s[DROP_W] ? '1 : s[DROP_W-1:0];
  endfunction
endpackage

// File: rtl/nexus_nonce_collector_if.sv
// nexus_nonce_collector_if: byte stream toward the host TX path.
//   TxData/TxValid driven by the master (collector), TxReady driven by the slave (sink).
interface nexus_nonce_collector_if;
  logic [7:0] TxData;
  logic TxValid;
  logic TxReady;
  modport master(output TxData, TxValid, input TxReady);
  modport slave(input TxData, TxValid, output TxReady);
endinterface

// File: rtl/nexus_nonce_fifo.sv
// nexus_nonce_fifo: synchronous first-word-fall-through FIFO with occupancy count.
//   clk/rst_n: clock, async active-low reset; clr_i: sync clear
//   wr_i/wdata_i: push; rd_i/rdata_o: pop with head always visible
//   full_o/empty_o/count_o: status
module nexus_nonce_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic wr_i,
  input  logic [W-1:0] wdata_i,
  input  logic rd_i,
  output logic [W-1:0] rdata_o,
  output logic full_o,
  output logic empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wr_en, rd_en;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == CW'(DEPTH);
  assign count_o = cnt_q;
  assign wr_en = wr_i && (!full_o || rd_i);
  assign rd_en = rd_i && (!empty_o || wr_i);
  // Reading while empty returns the word being written this cycle.
  assign rdata_o = empty_o ? wdata_i : mem_q[rp_q];
  always_comb begin
    wp_d = clr_i ? '0 : wp_q + AW'(wr_en);
    rp_d = clr_i ? '0 : rp_q + AW'(rd_en);
    cnt_d = clr_i ? '0 : cnt_q + CW'(wr_en) - CW'(rd_en);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wp_q] <= wdata_i;
  end
endmodule

// File: rtl/nexus_nonce_collector.sv
// nexus_nonce_collector: captures per-core nonces, merges them round-robin into a FIFO and frames them as bytes.
//   clk, nRst (async active-low), Flush (sync discard of pending nonces)
//   CoreNonce/CoreFound: per-core nonce and found pulse
//   tx: framed byte stream (4E header + 8 little-endian nonce bytes)
//   FifoCount, DropCount (saturating), Overflow (sticky): loss and occupancy status
module nexus_nonce_collector
  import nexus_pkg::*;
#(
  parameter int HASHERS = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic clk,
  input  logic nRst,
  input  logic Flush,
  input  logic [NONCE_W*HASHERS-1:0] CoreNonce,
  input  logic [HASHERS-1:0] CoreFound,
  nexus_nonce_collector_if.master tx,
  output logic [$clog2(FIFO_DEPTH):0] FifoCount,
  output logic [DROP_W-1:0] DropCount,
  output logic Overflow
);
  localparam int PW = HASHERS > 1 ? $clog2(HASHERS) : 1;
  localparam int BW = $clog2(FRAME_BYTES);
  logic [NONCE_W-1:0] slot_q [HASHERS];
  logic [HASHERS-1:0] slot_v_q, slot_v_d, drain, load, drop;
  logic [PW-1:0] ptr_q, ptr_d, grant_idx;
  logic grant_v, gnt;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic ovf_q, ovf_d;
  logic fifo_full, fifo_empty, pop;
  logic [NONCE_W-1:0] fifo_rdata;
  ser_state_e state_q, state_d;
  logic [NONCE_W-1:0] sh_q, sh_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic valid_q, valid_d, adv, last;
  // Scan from the highest offset down so the lowest offset from ptr_q wins.
  always_comb begin
    grant_v = 1'b0;
    grant_idx = '0;
    for (int k = HASHERS - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr_q) + k;
      j = j >= HASHERS ? j - HASHERS : j;
      if (slot_v_q[j]) begin
        grant_v = 1'b1;
        grant_idx = PW'(j);
      end
    end
  end
  assign gnt = grant_v && !fifo_full && !Flush;
  assign drain = gnt ? HASHERS'(1) << grant_idx : '0;
  // A slot being drained this cycle accepts a new nonce without loss.
  assign load = Flush ? '0 : CoreFound & (~slot_v_q | drain);
  assign drop = Flush ? '0 : CoreFound & slot_v_q & ~drain;
  always_comb begin
    slot_v_d = Flush ? '0 : (slot_v_q & ~drain) | load;
    ptr_d = Flush ? '0 : !gnt ? ptr_q : grant_idx == PW'(HASHERS - 1) ? '0 : grant_idx + PW'(1);
    drop_d = sat_add(drop_q, DROP_W'($countones(drop)));
    ovf_d = ovf_q | (|drop);
  end
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      slot_v_q <= '0;
      ptr_q <= '0;
      drop_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      slot_v_q <= slot_v_d;
      ptr_q <= ptr_d;
      drop_q <= drop_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < HASHERS; i++)
      if (load[i]) slot_q[i] <= CoreNonce[NONCE_W*i +: NONCE_W];
  end
  nexus_nonce_fifo #(.W(NONCE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(nRst),
    .clr_i(Flush),
    .wr_i(gnt),
    .wdata_i(slot_q[grant_idx]),
    .rd_i(pop),
    .rdata_o(fifo_rdata),
    .full_o(fifo_full),
    .empty_o(fifo_empty),
    .count_o(FifoCount)
  );
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      sh_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      valid_q <= valid_d;
    end
  end
  // Flush suppresses the pop so no discarded entry starts a frame; a frame in flight is untouched.
  always_comb begin
    last = state_q == DATA && cnt_q == BW'(FRAME_BYTES - 1);
    state_d = state_q == IDLE ? (!fifo_empty && !Flush ? HDR : IDLE) :
              state_q == HDR ? (tx.TxReady ? DATA : HDR) :
              (tx.TxReady && last) ? IDLE : DATA;
  end
  always_comb begin
    pop = state_q == IDLE && !fifo_empty && !Flush;
    adv = state_q != IDLE && tx.TxReady;
    sh_d = pop ? fifo_rdata : adv ? sh_q >> 8 : sh_q;
    cnt_d = state_q == HDR ? '0 : (state_q == DATA && adv) ? cnt_q + BW'(1) : cnt_q;
    data_d = pop ? FRAME_HDR : (adv && !last) ? sh_q[7:0] : data_q;
    valid_d = pop ? 1'b1 : (adv && last) ? 1'b0 : valid_q;
  end
  assign tx.TxData = data_q;
  assign tx.TxValid = valid_q;
  assign DropCount = drop_q;
  assign Overflow = ovf_q;
endmodule
